// File: rtl/spi_xfer_queue.sv
// Byte-queueing front end for an SPI master: TX FIFO feeds one master transfer
// per byte, received bytes land in an RX FIFO (first-word fall-through).
module spi_xfer_queue #(
  parameter int DEPTH            = 8,
  parameter bit STALL_ON_RX_FULL = 1'b1,
  parameter int CW               = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          tx_full,
  output logic [CW-1:0] tx_count,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rx_empty,
  output logic [CW-1:0] rx_count,
  output logic          rx_overflow,
  input  logic          clr_ovf,
  output logic          busy,
  output logic          spi_start,
  output logic [7:0]    spi_data_in,
  input  logic          spi_done,
  input  logic [7:0]    spi_data_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  logic [1:0]    state;
  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic          tx_empty, rx_full;
  logic          tx_push, tx_pop, rx_push, rx_pop, rx_done, ovf_set;

  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);

  // A launch is the only TX pop; it may be held off while RX has no room.
  assign tx_pop  = (state == ST_IDLE) && !tx_empty &&
                   (!STALL_ON_RX_FULL || !rx_full);
  assign tx_push = wr_en && (!tx_full || tx_pop);
  assign rx_done = (state == ST_WAIT) && spi_done;
  assign rx_pop  = rd_en && !rx_empty;
  assign rx_push = rx_done && (!rx_full || rx_pop);
  assign ovf_set = rx_done && !rx_push;

  assign rd_data = rx_empty ? 8'h00 : rx_mem[rx_rp];
  assign busy    = (state != ST_IDLE) || !tx_empty;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wr_data;
    if (rx_push) rx_mem[rx_wp] <= spi_data_out;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wp       <= '0;
      rx_rp       <= '0;
      rx_count    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
      if (ovf_set)      rx_overflow <= 1'b1;
      else if (clr_ovf) rx_overflow <= 1'b0;
    end
  end

  // spi_data_in only changes on a launch, so it is stable for the master's latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      spi_start   <= 1'b0;
      spi_data_in <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_pop) begin
            spi_data_in <= tx_mem[tx_rp];
            spi_start   <= 1'b1;
            state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          spi_start <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (spi_done) state <= ST_IDLE;
        end
        default: begin
          spi_start <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
